sum_to_bcd_converter: RTL

SUM_TO_BCD_CONVERTER -- requirements
Module: sum_to_bcd_converter

---
 rtl/sum_to_bcd_converter.sv | 117 +++++++++++
 1 files changed

// File: rtl/sum_to_bcd_converter.sv
// Iterative double-dabble converter for the 9-bit adder result {cout_in, sum_in}.
// One bit is shifted in per clock; three BCD digits are presented for the LCD path.
module sum_to_bcd_converter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] sum_in,
  input  logic       cout_in,
  output logic [3:0] bcd_hundreds,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StFinish
  } state_e;

  state_e      state_q, state_d;
  logic [8:0]  shift_q, shift_d;
  logic [11:0] scratch_q, scratch_d;
  logic [3:0]  count_q, count_d;
  logic [3:0]  hundreds_q, hundreds_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  ones_q, ones_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [11:0] adjusted;

  // Per-nibble add-3 correction; nibbles never carry into each other.
  always_comb begin
    adjusted = scratch_q;
    for (int n = 0; n < 3; n++) begin
      if (scratch_q[n*4 +: 4] >= 4'd5) begin
        adjusted[n*4 +: 4] = scratch_q[n*4 +: 4] + 4'd3;
      end
    end
  end

  // Next-state and output decode; digits only change on the finish step.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    count_d    = count_q;
    hundreds_d = hundreds_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          shift_d   = {cout_in, sum_in};
          scratch_d = 12'd0;
          count_d   = 4'd0;
          state_d   = StShift;
        end
      end
      StShift: begin
        busy_d    = 1'b1;
        scratch_d = {adjusted[10:0], shift_q[8]};
        shift_d   = {shift_q[7:0], 1'b0};
        count_d   = count_q + 4'd1;
        // Leave after the ninth shift so the counter stops at 9.
        if (count_q == 4'd8) begin
          state_d = StFinish;
        end
      end
      StFinish: begin
        hundreds_d = scratch_q[11:8];
        tens_d     = scratch_q[7:4];
        ones_d     = scratch_q[3:0];
        done_d     = 1'b1;
        state_d    = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      shift_q    <= 9'd0;
      scratch_q  <= 12'd0;
      count_q    <= 4'd0;
      hundreds_q <= 4'd0;
      tens_q     <= 4'd0;
      ones_q     <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      count_q    <= count_d;
      hundreds_q <= hundreds_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bcd_hundreds = hundreds_q;
  assign bcd_tens     = tens_q;
  assign bcd_ones     = ones_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
